// File: rtl/xgemac_pkg.sv
// Common types and defaults for the XGEMAC transmit packet sink.
package xgemac_pkg;

  `include "xgemac_defines.sv"

  localparam int DATA_W = `XGEMAC_TX_RX_DATA_WIDTH;
  localparam int MOD_W  = `XGEMAC_TX_RX_MOD;

  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_FULL_MARGIN = 2;

  // Framing state of the incoming packet stream
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } fsm_state_t;

  // One buffered word; err marks a packet start whose predecessor lost its eop
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic              err;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Statistics counters stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xgemac_defines.sv
// Shared width defines for the XGEMAC packet interface.
`ifndef XGEMAC_DEFINES_SV
`define XGEMAC_DEFINES_SV

`define XGEMAC_TX_RX_DATA_WIDTH 64
`define XGEMAC_TX_RX_MOD 3

`endif

// File: rtl/xgemac_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push while full succeeds only
// when a pop happens in the same cycle.
module xgemac_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array is not reset; the occupancy count guards every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xgemac_tx_pkt_sink.sv
// Transmit packet sink: validates sop/eop framing, buffers accepted words in
// a FWFT FIFO, discards malformed or overflowing traffic and counts both.
module xgemac_tx_pkt_sink
  import xgemac_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int FULL_MARGIN = DEFAULT_FULL_MARGIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pkt_tx_data,
  input  logic              pkt_tx_val,
  input  logic              pkt_tx_sop,
  input  logic              pkt_tx_eop,
  input  logic [MOD_W-1:0]  pkt_tx_mod,
  output logic              pkt_tx_full,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [MOD_W-1:0]  out_mod,
  output logic              out_err,
  output logic              out_val,
  input  logic              out_rdy,
  output logic              err_nosop,
  output logic              err_sop_in_pkt,
  output logic              err_ovf,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - FULL_MARGIN);

  fsm_state_t          state;
  fsm_state_t          state_nxt;
  fifo_entry_t         wr_entry;
  fifo_entry_t         head;
  logic [ENTRY_W-1:0]  rd_bits;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       count_nxt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                can_write;
  logic                push;
  logic                wr_err;
  logic                nosop_c;
  logic                sip_c;
  logic                ovf_c;
  logic                pkt_inc;
  logic                drop_inc;

  assign pop       = out_val && out_rdy;
  assign can_write = !fifo_full || pop;
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);

  xgemac_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_bits),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Framing state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Framing transitions; an overflow mid-packet sends the rest of it to DROP
  always_comb begin
    state_nxt = state;
    if (pkt_tx_val) begin
      case (state)
        IDLE: begin
          if (pkt_tx_sop && !pkt_tx_eop) begin
            state_nxt = can_write ? IN_PKT : DROP;
          end
        end
        IN_PKT: begin
          if (pkt_tx_eop) begin
            state_nxt = IDLE;
          end else if (!can_write) begin
            state_nxt = DROP;
          end
        end
        DROP: begin
          if (pkt_tx_eop) begin
            state_nxt = IDLE;
          end else if (pkt_tx_sop && can_write) begin
            state_nxt = IN_PKT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-word actions: store or discard, and which error/counter events fire
  always_comb begin
    push     = 1'b0;
    wr_err   = 1'b0;
    nosop_c  = 1'b0;
    sip_c    = 1'b0;
    ovf_c    = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (pkt_tx_val) begin
      case (state)
        IDLE: begin
          if (!pkt_tx_sop) begin
            nosop_c  = 1'b1;
            drop_inc = 1'b1;
          end else if (can_write) begin
            push    = 1'b1;
            pkt_inc = 1'b1;
          end else begin
            ovf_c    = 1'b1;
            drop_inc = 1'b1;
          end
        end
        IN_PKT: begin
          sip_c = pkt_tx_sop;
          if (can_write) begin
            push    = 1'b1;
            wr_err  = pkt_tx_sop;
            pkt_inc = pkt_tx_sop;
          end else begin
            ovf_c    = 1'b1;
            drop_inc = 1'b1;
          end
        end
        DROP: begin
          if (pkt_tx_sop && !pkt_tx_eop && can_write) begin
            push    = 1'b1;
            pkt_inc = 1'b1;
          end else begin
            drop_inc = 1'b1;
          end
        end
        default: begin
          drop_inc = 1'b1;
        end
      endcase
    end
  end

  // Assemble the FIFO entry; mod only carries meaning on the last word
  always_comb begin
    wr_entry      = '0;
    wr_entry.data = pkt_tx_data;
    wr_entry.sop  = pkt_tx_sop;
    wr_entry.eop  = pkt_tx_eop;
    wr_entry.mod  = pkt_tx_eop ? pkt_tx_mod : {MOD_W{1'b0}};
    wr_entry.err  = wr_err;
  end

  // Registered error pulses, statistics and early backpressure flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_nosop      <= 1'b0;
      err_sop_in_pkt <= 1'b0;
      err_ovf        <= 1'b0;
      pkt_cnt        <= '0;
      drop_cnt       <= '0;
      pkt_tx_full    <= 1'b0;
    end else begin
      err_nosop      <= nosop_c;
      err_sop_in_pkt <= sip_c;
      err_ovf        <= ovf_c;
      if (pkt_inc) begin
        pkt_cnt <= sat_inc16(pkt_cnt);
      end
      if (drop_inc) begin
        drop_cnt <= sat_inc16(drop_cnt);
      end
      pkt_tx_full <= (count_nxt >= FULL_TH);
    end
  end

  assign head     = rd_bits;
  assign out_val  = !fifo_empty;
  assign out_data = out_val ? head.data : '0;
  assign out_sop  = out_val && head.sop;
  assign out_eop  = out_val && head.eop;
  assign out_mod  = out_val ? head.mod : '0;
  assign out_err  = out_val && head.err;

endmodule

// File: tb/tb_xgemac_tx_pkt_sink.sv
// Testbench for xgemac_tx_pkt_sink: directed framing scenarios followed by
// random traffic, all compared against a queue-based packet model.
module tb_xgemac_tx_pkt_sink;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        pkt_tx_full;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_mod;
  logic        out_err;
  logic        out_val;
  logic        out_rdy;
  logic        err_nosop;
  logic        err_sop_in_pkt;
  logic        err_ovf;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  xgemac_tx_pkt_sink #(
    .DEPTH       (DEPTH),
    .FULL_MARGIN (MARGIN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_full    (pkt_tx_full),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_mod        (out_mod),
    .out_err        (out_err),
    .out_val        (out_val),
    .out_rdy        (out_rdy),
    .err_nosop      (err_nosop),
    .err_sop_in_pkt (err_sop_in_pkt),
    .err_ovf        (err_ovf),
    .pkt_cnt        (pkt_cnt),
    .drop_cnt       (drop_cnt)
  );

  // Reference model: expected FIFO contents plus the framing situation
  typedef struct {
    logic [63:0] data;
    bit          sop;
    bit          eop;
    bit [2:0]    mod;
    bit          err;
  } exp_word_t;

  typedef enum {M_BETWEEN, M_INSIDE, M_DISCARD} mode_t;

  exp_word_t exp_q[$];
  mode_t     mode;
  int        m_pkts;
  int        m_drops;
  bit        m_nosop;
  bit        m_sip;
  bit        m_ovf;
  bit        m_full;

  int total = 0;
  int bad   = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic void modelReset();
    exp_q.delete();
    mode    = M_BETWEEN;
    m_pkts  = 0;
    m_drops = 0;
    m_nosop = 0;
    m_sip   = 0;
    m_ovf   = 0;
    m_full  = 0;
  endfunction

  // One clock of the packet rules applied to the word on the inputs
  function automatic void modelStep(input bit val, input bit sop, input bit eop,
                                    input bit [2:0] mod, input logic [63:0] data,
                                    input bit rdy);
    bit        pop;
    bit        room;
    bit        store;
    exp_word_t w;
    pop     = rdy && (exp_q.size() > 0);
    room    = (exp_q.size() < DEPTH) || pop;
    store   = 0;
    w.err   = 0;
    m_nosop = 0;
    m_sip   = 0;
    m_ovf   = 0;
    if (val) begin
      if (mode == M_DISCARD) begin
        if (sop && !eop && room) begin
          store = 1;
          mode  = M_INSIDE;
        end else begin
          m_drops = sat16(m_drops + 1);
          if (eop) mode = M_BETWEEN;
        end
      end else if (mode == M_BETWEEN && !sop) begin
        m_nosop = 1;
        m_drops = sat16(m_drops + 1);
      end else begin
        if (mode == M_INSIDE && sop) m_sip = 1;
        if (room) begin
          store = 1;
          w.err = (mode == M_INSIDE) && sop;
          mode  = eop ? M_BETWEEN : M_INSIDE;
        end else begin
          m_ovf   = 1;
          m_drops = sat16(m_drops + 1);
          mode    = eop ? M_BETWEEN : M_DISCARD;
        end
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (store) begin
      w.data = data;
      w.sop  = sop;
      w.eop  = eop;
      w.mod  = eop ? mod : 3'd0;
      exp_q.push_back(w);
      if (sop) m_pkts = sat16(m_pkts + 1);
    end
    m_full = (exp_q.size() >= DEPTH - MARGIN);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_val", 64'(out_val), 64'(exp_q.size() > 0));
    checkOutput("pkt_tx_full", 64'(pkt_tx_full), 64'(m_full));
    checkOutput("err_nosop", 64'(err_nosop), 64'(m_nosop));
    checkOutput("err_sop_in_pkt", 64'(err_sop_in_pkt), 64'(m_sip));
    checkOutput("err_ovf", 64'(err_ovf), 64'(m_ovf));
    checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    if (exp_q.size() > 0) begin
      checkOutput("out_data", out_data, exp_q[0].data);
      checkOutput("out_sop", 64'(out_sop), 64'(exp_q[0].sop));
      checkOutput("out_eop", 64'(out_eop), 64'(exp_q[0].eop));
      checkOutput("out_mod", 64'(out_mod), 64'(exp_q[0].mod));
      checkOutput("out_err", 64'(out_err), 64'(exp_q[0].err));
    end
  endtask

  // Drive one cycle at a falling edge, advance the model, check at the next falling edge
  task automatic applyStimulus(input bit val, input bit sop, input bit eop,
                               input bit [2:0] mod, input logic [63:0] data,
                               input bit rdy);
    pkt_tx_val  = val;
    pkt_tx_sop  = sop;
    pkt_tx_eop  = eop;
    pkt_tx_mod  = mod;
    pkt_tx_data = data;
    out_rdy     = rdy;
    modelStep(val, sop, eop, mod, data, rdy);
    @(negedge clk);
    checkAll();
  endtask

  // Idle cycle with junk on the ignored inputs
  task automatic idleCycle(input bit rdy);
    applyStimulus(1'b0, 1'($urandom), 1'($urandom), 3'($urandom),
                  {$urandom, $urandom}, rdy);
  endtask

  // Asynchronous reset mid-cycle, released on a falling edge
  task automatic doReset();
    pkt_tx_val = 1'b0;
    out_rdy    = 1'b0;
    #3 rst = 1'b0;
    #1;
    checkOutput("rst_out_val", 64'(out_val), 64'd0);
    checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("rst_full", 64'(pkt_tx_full), 64'd0);
    modelReset();
    @(negedge clk);
    checkAll();
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    pkt_tx_val  = 1'b0;
    pkt_tx_sop  = 1'b0;
    pkt_tx_eop  = 1'b0;
    pkt_tx_mod  = 3'd0;
    pkt_tx_data = '0;
    out_rdy     = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkAll();
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_sop", 64'(out_sop), 64'd0);
    checkOutput("rst_out_eop", 64'(out_eop), 64'd0);
    checkOutput("rst_out_err", 64'(out_err), 64'd0);
    checkOutput("rst_out_mod", 64'(out_mod), 64'd0);
    rst = 1'b1;
    $display("[TB] reset released");

    // Three-word packet streaming straight through
    applyStimulus(1, 1, 0, 3'd7, 64'h1111_0000_0000_0001, 1);
    applyStimulus(1, 0, 0, 3'd6, 64'h2222_0000_0000_0002, 1);
    applyStimulus(1, 0, 1, 3'd5, 64'h3333_0000_0000_0003, 1);
    idleCycle(1);
    idleCycle(1);
    checkOutput("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    doReset();

    // Six single-word packets with the sink stalled, then drain
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 1, 3'(i), 64'hA000 + 64'(i), 0);
      checkOutput("t2_full_edge", 64'(pkt_tx_full), (i == 5) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 8; i++) idleCycle(1);
    checkOutput("t2_drained", 64'(out_val), 64'd0);
    doReset();

    // Ten-word packet into an eight-deep stalled FIFO
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, i == 0, i == 9, 3'd3, 64'hB000 + 64'(i), 0);
    end
    checkOutput("t3_drop_cnt", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 10; i++) idleCycle(1);
    doReset();

    // Word without sop between packets
    applyStimulus(1, 0, 0, 3'd0, 64'hC0DE, 1);
    checkOutput("t4_drop_cnt", 64'(drop_cnt), 64'd1);
    checkOutput("t4_out_val", 64'(out_val), 64'd0);
    doReset();

    // Packet restarted by a second sop
    applyStimulus(1, 1, 0, 3'd0, 64'hD001, 1);
    applyStimulus(1, 0, 0, 3'd0, 64'hD002, 1);
    applyStimulus(1, 1, 0, 3'd0, 64'hD003, 1);
    applyStimulus(1, 0, 1, 3'd2, 64'hD004, 1);
    idleCycle(1);
    checkOutput("t5_pkt_cnt", 64'(pkt_cnt), 64'd2);
    doReset();

    // Reset with three words buffered mid-packet, then recovery
    applyStimulus(1, 1, 0, 3'd0, 64'hE001, 0);
    applyStimulus(1, 0, 0, 3'd0, 64'hE002, 0);
    applyStimulus(1, 0, 0, 3'd0, 64'hE003, 0);
    doReset();
    applyStimulus(1, 0, 1, 3'd1, 64'hE004, 1);
    applyStimulus(1, 1, 0, 3'd0, 64'hE005, 1);
    applyStimulus(1, 0, 1, 3'd4, 64'hE006, 1);
    idleCycle(1);

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) < 3, 3'($urandom),
                    {$urandom, $urandom}, $urandom_range(0, 9) < 5);
    end
    for (int i = 0; i < DEPTH + 2; i++) idleCycle(1);
    checkOutput("final_empty", 64'(out_val), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xgemac_tx_pkt_sink.md
XGEMAC_TX_PKT_SINK -- requirements
Module: xgemac_tx_pkt_sink

Interface
REQ-001 Parameter DEPTH, default 8: FIFO depth in words, a power of two and at least 4.
REQ-002 Parameter FULL_MARGIN, default 2: free-slot headroom at which pkt_tx_full asserts.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset), released synchronously to clk.
REQ-005 pkt_tx_data  in  `XGEMAC_TX_RX_DATA_WIDTH (64)  packet word.
REQ-006 pkt_tx_val  in  1  word valid.
REQ-007 pkt_tx_sop  in  1  first word of packet.
REQ-008 pkt_tx_eop  in  1  last word of packet.
REQ-009 pkt_tx_mod  in  `XGEMAC_TX_RX_MOD (3)  valid bytes on eop word; 0 = all 8 valid.
REQ-010 pkt_tx_full  out  1  backpressure to packet source.
REQ-011 out_data/out_sop/out_eop/out_mod  out  64/1/1/3  FIFO head word.
REQ-012 out_err  out  1  head word starts a packet whose predecessor was truncated.
REQ-013 out_val  out  1  head valid.
REQ-014 out_rdy  in  1  downstream accepts the head; the pop occurs when out_val and out_rdy are both high.
REQ-015 err_nosop, err_sop_in_pkt, err_ovf  out  1 each  single-cycle error pulses.
REQ-016 pkt_cnt, drop_cnt  out  16 each  packets accepted and words discarded.

Function
REQ-017 Framing FSM states: IDLE, IN_PKT, DROP.
REQ-018 IDLE with val&sop: write the word; next state is IDLE if eop, else IN_PKT.
REQ-019 IDLE with val and no sop: discard the word, pulse err_nosop, increment drop_cnt, remain in IDLE.
REQ-020 IN_PKT with val and no sop: write the word; return to IDLE on eop.
REQ-021 IN_PKT with val&sop: write the word with out_err=1 as a new packet start, pulse err_sop_in_pkt, and increment pkt_cnt for the new packet only.
REQ-022 Any val word arriving while the FIFO is full (count==DEPTH with no pop this cycle) is dropped, pulses err_ovf and increments drop_cnt.
REQ-023 An overflow on a word without eop moves the FSM to DROP.
REQ-024 DROP discards every val word and increments drop_cnt for each, leaving to IDLE on the eop word.
REQ-025 In DROP, val&sop&eop is discarded and the FSM returns to IDLE.
REQ-026 In DROP, val&sop without eop is accepted as a normal new packet start and the FSM goes to IN_PKT.
REQ-027 Stored mod equals pkt_tx_mod on eop words and is forced to 0 on all other words.
REQ-028 pkt_cnt increments when an sop word is written to the FIFO.
REQ-029 pkt_cnt and drop_cnt saturate at 16'hFFFF.
REQ-030 Simultaneous push and pop is legal at any occupancy, including full, where both succeed and count is unchanged.
REQ-031 Latency: a word written at edge N is visible with out_val=1 after edge N; the FIFO is first-word-fall-through.
REQ-032 pkt_tx_full is registered: high on the cycle after edge N when the post-edge-N count is at least DEPTH-FULL_MARGIN, and low otherwise.
REQ-033 Inputs other than val are ignored when val=0.

Reset
REQ-034 While rst=0, all of the following are 0: FSM (IDLE), FIFO pointers and count, out_val, out_sop, out_eop, out_err, out_mod, out_data, pkt_tx_full, error pulses, pkt_cnt and drop_cnt.
REQ-035 Reset asserted mid-packet discards FIFO contents; the first post-reset word without sop takes the err_nosop path.

Structure
REQ-036 Package xgemac_pkg holds the FSM state enum, the FIFO entry struct {data, sop, eop, mod, err}, and the DEPTH/FULL_MARGIN defaults.
REQ-037 The width defines come from xgemac_defines.sv.
REQ-038 Storage is one sub-module, xgemac_sync_fifo: parameterized width and depth, with push, pop, count, full and empty.

Verification
REQ-039 3-word packet with out_rdy=1 -> out words match data, sop on word 0, eop+mod=5 on word 2, pkt_cnt=1, no errors.
REQ-040 out_rdy=0, 6 single-word packets with DEPTH=8 -> pkt_tx_full rises the cycle after the 6th write; all 6 drain in order when out_rdy=1.
REQ-041 out_rdy=0, 10-word packet ignoring full -> 8 stored, err_ovf pulse on word 9, drop_cnt=2, FSM IDLE after eop.
REQ-042 Word without sop in IDLE -> err_nosop pulse, drop_cnt=1, out_val stays 0.
REQ-043 sop, data, sop, eop -> err_sop_in_pkt pulse, 4 words out, 3rd word out_err=1, pkt_cnt=2.
REQ-044 rst=0 mid-packet with 3 words buffered -> out_val=0 and counters=0 immediately; post-reset sop packet passes cleanly.
